// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding and ALU opcode constants for the mul/div unit
package muldiv_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // ALU opcodes shared by decode and the ALU result mux
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_MFLO = 4'b1010;
    localparam logic [3:0] ALU_MFHI = 4'b1011;

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate for operand magnitudes and results
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    // Negate when requested, otherwise pass through
    always_comb begin
        result = neg ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide owning HI/LO (MTHI/MTLO via MULDIV_MTHI_MTLO_EN)
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             Unsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import muldiv_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   count;
    // Multiply: {partial product, remaining multiplier}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;
    // Multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   opnd;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifndef MULDIV_MTHI_MTLO_EN
    // MTHI/MTLO ports are kept for interface stability but have no effect here
    logic unused_ok;
    assign unused_ok = ^{wr_hi, wr_lo, wdata};
`endif

    // Operand signs only matter for signed ops
    always_comb begin
        a_neg = ~Unsigned & A[WIDTH-1];
        b_neg = ~Unsigned & B[WIDTH-1];
    end

    muldiv_signfix #(.W(WIDTH)) u_mag_a (.value(A), .neg(a_neg), .result(mag_a));
    muldiv_signfix #(.W(WIDTH)) u_mag_b (.value(B), .neg(b_neg), .result(mag_b));

    // One shift-add or restoring-divide step from the current working registers
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        end
        step_next = op_div ? div_next : mul_next;
    end

    // Sign correction is applied to the final step so the result lands on the last CALC edge
    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.value(mul_next), .neg(neg_q), .result(prod_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_quo (.value(div_next[WIDTH-1:0]), .neg(neg_q), .result(quo_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (.value(div_next[2*WIDTH-1:WIDTH]), .neg(neg_r), .result(rem_fix));

    // Control FSM, working registers and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_div <= is_div;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        opnd   <= mag_b;
                        count  <= '0;
                        busy   <= 1'b1;
                        if (is_div && (B == '0)) begin
                            // Divide by zero skips iteration: all-ones quotient, dividend as remainder
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            lo       <= '1;
                            hi       <= A;
                        end else begin
                            state    <= CALC;
                            div_zero <= 1'b0;
                        end
                    end
`ifdef MULDIV_MTHI_MTLO_EN
                    else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
`endif
                end
                CALC: begin
                    acc   <= step_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_div;
    logic        Unsigned;
    logic [31:0] A;
    logic [31:0] B;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .is_div(is_div), .Unsigned(Unsigned),
        .A(A), .B(B), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one op, then scramble operands while it runs; observe on negedges after the start edge
    task automatic run_op(input logic div, input logic uns, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_cycle, output int done_count);
        @(negedge clk);
        start = 1'b1; is_div = div; Unsigned = uns; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = 32'hDEADBEEF; B = 32'h0000_0003;
        busy_cycles = 0; done_cycle = -1; done_count = 0;
        for (int i = 1; i <= 60; i++) begin
            if (busy) busy_cycles++;
            if (done) begin done_count++; done_cycle = i; end
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", lo); end
    endtask

    task automatic test_multu();
        int bc, dc, dn;
        run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'h2, bc, dc, dn);
        vectors++; if (bc !== 33) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        vectors++; if (dc !== 33) begin miscompares++; $display("FAIL multu_done_cycle: got %0d want 33", dc); end
        vectors++; if (dn !== 1) begin miscompares++; $display("FAIL multu_done_pulses: got %0d want 1", dn); end
        vectors++; if (hi !== 32'h00000001) begin miscompares++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        vectors++; if (lo !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_mult_signed();
        int bc, dc, dn;
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h2, bc, dc, dn);
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_m1x2_hi: got %h want ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL mult_m1x2_lo: got %h want fffffffe", lo); end
        run_op(1'b0, 1'b0, 32'hFFFFFFFD, 32'h5, bc, dc, dn);
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_m3x5_hi: got %h want ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFFFFF1) begin miscompares++; $display("FAIL mult_m3x5_lo: got %h want fffffff1", lo); end
        vectors++; if (bc !== 33) begin miscompares++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
    endtask

    task automatic test_div_signed();
        int bc, dc, dn;
        run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'h2, bc, dc, dn);
        vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_m7_2_lo: got %h want fffffffd", lo); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_m7_2_hi: got %h want ffffffff", hi); end
        vectors++; if (dc !== 33) begin miscompares++; $display("FAIL div_done_cycle: got %0d want 33", dc); end
        run_op(1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFE, bc, dc, dn);
        vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_7_m2_lo: got %h want fffffffd", lo); end
        vectors++; if (hi !== 32'h00000001) begin miscompares++; $display("FAIL div_7_m2_hi: got %h want 00000001", hi); end
        run_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, bc, dc, dn);
        vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL div_intmin_lo: got %h want 80000000", lo); end
        vectors++; if (hi !== 32'h00000000) begin miscompares++; $display("FAIL div_intmin_hi: got %h want 00000000", hi); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL div_intmin_div_zero: got %b want 0", div_zero); end
    endtask

    task automatic test_div_zero();
        int bc, dc, dn;
        run_op(1'b1, 1'b1, 32'h00001234, 32'h0, bc, dc, dn);
        vectors++; if (bc !== 1) begin miscompares++; $display("FAIL divz_busy_cycles: got %0d want 1", bc); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL divz_done_cycle: got %0d want 1", dc); end
        vectors++; if (lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
        vectors++; if (hi !== 32'h00001234) begin miscompares++; $display("FAIL divz_hi: got %h want 00001234", hi); end
        vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL divz_flag: got %b want 1", div_zero); end
        repeat (3) @(negedge clk);
        vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL divz_sticky: got %b want 1", div_zero); end
        run_op(1'b1, 1'b1, 32'd100, 32'd7, bc, dc, dn);
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL divz_cleared: got %b want 0", div_zero); end
        vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_100_7_lo: got %h want 0000000e", lo); end
        vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_100_7_hi: got %h want 00000002", hi); end
    endtask

    // Previous result is 100/7 (hi=2, lo=14); a start pulse mid-CALC must be ignored
    task automatic test_start_while_busy();
        int bc;
        @(negedge clk);
        start = 1'b1; is_div = 1'b0; Unsigned = 1'b1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int i = 1; i <= 60; i++) begin
            if (busy) bc++;
            if (i == 5) begin
                vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL busy_lo_hold: got %h want 0000000e", lo); end
                vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL busy_hi_hold: got %h want 00000002", hi); end
                start = 1'b1; is_div = 1'b1; A = 32'd100; B = 32'd0;
            end
            if (i == 6) start = 1'b0;
            if (!busy) break;
            @(negedge clk);
        end
        start = 1'b0;
        vectors++; if (bc !== 33) begin miscompares++; $display("FAIL busy_ignore_cycles: got %0d want 33", bc); end
        vectors++; if (lo !== 32'd12) begin miscompares++; $display("FAIL busy_ignore_lo: got %h want 0000000c", lo); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL busy_ignore_hi: got %h want 00000000", hi); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL busy_ignore_div_zero: got %b want 0", div_zero); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_ignore_idle: got %b want 0", busy); end
    endtask

    // Previous result hi=0, lo=12; run MULTU and reset at iteration 10
    task automatic test_reset_abort();
        int seen;
        run_op(1'b0, 1'b1, 32'h00001000, 32'h00000010, seen, seen, seen);
        vectors++; if (lo !== 32'h00010000) begin miscompares++; $display("FAIL pre_abort_lo: got %h want 00010000", lo); end
        @(negedge clk);
        start = 1'b1; is_div = 1'b0; Unsigned = 1'b1; A = 32'hFFFFFFFF; B = 32'h2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", done); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL abort_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL abort_lo: got %h want 0", lo); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d want 0", seen); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL abort_lo_after: got %h want 0", lo); end
    endtask

    // hi = lo = 0 on entry
    task automatic test_mthi_mtlo();
`ifdef MULDIV_MTHI_MTLO_EN
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        wr_hi = 1'b0;
        vectors++; if (hi !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mthi_idle: got %h want cafef00d", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL mthi_lo_untouched: got %h want 0", lo); end
        wr_lo = 1'b1; wdata = 32'h0BADBEEF;
        @(negedge clk);
        wr_lo = 1'b0;
        vectors++; if (lo !== 32'h0BADBEEF) begin miscompares++; $display("FAIL mtlo_idle: got %h want 0badbeef", lo); end
        start = 1'b1; is_div = 1'b0; Unsigned = 1'b1; A = 32'd2; B = 32'd3;
        wr_lo = 1'b1; wdata = 32'h55555555;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        vectors++; if (lo !== 32'h0BADBEEF) begin miscompares++; $display("FAIL mtlo_start_wins: got %h want 0badbeef", lo); end
        repeat (4) @(negedge clk);
        wr_hi = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        wr_hi = 1'b0;
        vectors++; if (hi !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mthi_busy_dropped: got %h want cafef00d", hi); end
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL mt_op_lo: got %h want 00000006", lo); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL mt_op_hi: got %h want 00000000", hi); end
`else
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL mthi_disabled: got %h want 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL mtlo_disabled: got %h want 0", lo); end
`endif
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; is_div = 1'b0; Unsigned = 1'b0;
        A = '0; B = '0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_div_signed();
        test_div_zero();
        test_start_while_busy();
        test_reset_abort();
        test_mthi_mtlo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
